calc_scoreboard: RTL and testbench

//  Parametrised per-port scoreboard for the calc testbench.

---
 rtl/calc_scoreboard_if.sv | 36 +++
 rtl/calc_scoreboard.sv | 192 +++++++++++++++++++
 tb/tb_calc_scoreboard.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_scoreboard_if.sv
// Bundles the reference-model, DUV-response and result buses of calc_scoreboard.
// All buses are flattened per channel: channel c lives at [c*W +: W].
interface calc_scoreboard_if #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int RW    = 2,
  parameter int DEPTH = 8,
  parameter int CW    = 16
);
  localparam int PW = $clog2(DEPTH) + 1;

  // Handshake: a nonzero resp code on exp_resp/duv_resp is the valid qualifier for
  // its channel in that cycle; there is no ready, every qualified beat is consumed.
  logic [NCH*RW-1:0] exp_resp;
  logic [NCH*DW-1:0] exp_data;
  logic [NCH*RW-1:0] duv_resp;
  logic [NCH*DW-1:0] duv_data;

  logic [NCH-1:0]    err_pulse;
  logic [NCH*3-1:0]  err_code;
  logic [NCH*PW-1:0] pending;
  logic [NCH*CW-1:0] match_cnt;
  logic [NCH*CW-1:0] err_cnt;
  logic              err_sticky;
  logic              all_idle;

  modport master (
    output exp_resp, exp_data, duv_resp, duv_data,
    input  err_pulse, err_code, pending, match_cnt, err_cnt, err_sticky, all_idle
  );

  modport slave (
    input  exp_resp, exp_data, duv_resp, duv_data,
    output err_pulse, err_code, pending, match_cnt, err_cnt, err_sticky, all_idle
  );
endinterface

// File: rtl/calc_scoreboard.sv
// Per-channel in-order scoreboard: queues reference responses, compares them against
// DUV responses, and reports mismatches, unexpected responses, overflow and timeouts.
module calc_scoreboard #(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int RW      = 2,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             clear,
  calc_scoreboard_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = RW + DW;

  typedef enum logic [2:0] {
    E_NONE  = 3'd0,
    E_DATA  = 3'd1,
    E_RESP  = 3'd2,
    E_UNEXP = 3'd3,
    E_OVFL  = 3'd4,
    E_TMO   = 3'd5
  } err_code_t;

  logic          pulse_a     [NCH];
  logic [2:0]    code_a      [NCH];
  logic [PW-1:0] count_a     [NCH];
  logic [PW-1:0] count_nxt_a [NCH];
  logic [CW-1:0] match_a     [NCH];
  logic [CW-1:0] err_a       [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [RW-1:0] e_resp, d_resp;
    logic [DW-1:0] e_data, d_data;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] ref_ent;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] count, count_nxt;
    logic [TW-1:0] age, age_nxt;
    logic          push, pop, empty, full;
    logic          wr_en, rd_en, is_match;
    err_code_t     code_nxt, code_q;
    logic          pulse_q;
    logic [CW-1:0] match_q, err_q;

    assign e_resp = sb.exp_resp[c*RW +: RW];
    assign e_data = sb.exp_data[c*DW +: DW];
    assign d_resp = sb.duv_resp[c*RW +: RW];
    assign d_data = sb.duv_data[c*DW +: DW];

    assign push  = |e_resp;
    assign pop   = |d_resp;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));

    // A DUV pop always outranks overflow/timeout, so the two branches never both report.
    always_comb begin
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      is_match = 1'b0;
      code_nxt = E_NONE;
      ref_ent  = mem[rd_ptr];
      if (pop) begin
        if (empty && !push) begin
          code_nxt = E_UNEXP;
        end else begin
          if (empty) begin
            ref_ent = {e_resp, e_data};
          end else begin
            rd_en = 1'b1;
            wr_en = push;
          end
          if (ref_ent[EW-1 -: RW] != d_resp) begin
            code_nxt = E_RESP;
          end else if (d_resp == RW'(1) && ref_ent[DW-1:0] != d_data) begin
            code_nxt = E_DATA;
          end else begin
            is_match = 1'b1;
          end
        end
      end else begin
        if (!empty && age == TW'(TIMEOUT - 1)) begin
          rd_en    = 1'b1;
          code_nxt = E_TMO;
        end
        if (push) begin
          if (full) code_nxt = E_OVFL;
          else      wr_en    = 1'b1;
        end
      end
    end

    assign count_nxt = count + PW'(wr_en) - PW'(rd_en);

    // Age restarts whenever a different entry becomes head; it never passes TIMEOUT-1
    // because the head is discarded on that cycle unless a pop takes it first.
    always_comb begin
      if (rd_en || (empty && wr_en) || count_nxt == '0) age_nxt = '0;
      else                                               age_nxt = age + TW'(1);
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        age     <= '0;
        pulse_q <= 1'b0;
        code_q  <= E_NONE;
        match_q <= '0;
        err_q   <= '0;
      end else if (clear) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        age     <= '0;
        pulse_q <= 1'b0;
        code_q  <= E_NONE;
        match_q <= '0;
        err_q   <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        count   <= count_nxt;
        age     <= age_nxt;
        pulse_q <= (code_nxt != E_NONE);
        code_q  <= code_nxt;
        if (is_match && match_q != '1)          match_q <= match_q + CW'(1);
        if (code_nxt != E_NONE && err_q != '1) err_q   <= err_q + CW'(1);
      end
    end

    always_ff @(posedge c_clk) begin
      if (wr_en && !clear) mem[wr_ptr] <= {e_resp, e_data};
    end

    assign pulse_a[c]     = pulse_q;
    assign code_a[c]      = code_q;
    assign count_a[c]     = count;
    assign count_nxt_a[c] = count_nxt;
    assign match_a[c]     = match_q;
    assign err_a[c]       = err_q;
  end

  logic any_pulse, none_pending_nxt;
  logic sticky_q, idle_q;

  always_comb begin
    any_pulse        = 1'b0;
    none_pending_nxt = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      any_pulse        = any_pulse | pulse_a[c];
      none_pending_nxt = none_pending_nxt & (count_nxt_a[c] == '0);
    end
  end

  // all_idle tracks the occupancy being loaded this cycle so it agrees with pending.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
      idle_q   <= 1'b1;
    end else if (clear) begin
      sticky_q <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      sticky_q <= sticky_q | any_pulse;
      idle_q   <= none_pending_nxt;
    end
  end

  always_comb begin
    sb.err_pulse = '0;
    sb.err_code  = '0;
    sb.pending   = '0;
    sb.match_cnt = '0;
    sb.err_cnt   = '0;
    for (int c = 0; c < NCH; c++) begin
      sb.err_pulse[c]          = pulse_a[c];
      sb.err_code[c*3 +: 3]    = code_a[c];
      sb.pending[c*PW +: PW]   = count_a[c];
      sb.match_cnt[c*CW +: CW] = match_a[c];
      sb.err_cnt[c*CW +: CW]   = err_a[c];
    end
    sb.err_sticky = sticky_q;
    sb.all_idle   = idle_q;
  end
endmodule

// File: tb/tb_calc_scoreboard.sv
// Bench for calc_scoreboard: directed scenarios plus random traffic, every cycle's
// outputs checked against a queue-based reference model through an expected queue.
module tb_calc_scoreboard;
  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int RW      = 2;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CW      = 8;
  localparam int PW      = $clog2(DEPTH) + 1;
  localparam int EW      = RW + DW;
  localparam int CHW     = 4 + PW + 2*CW;
  localparam int W       = NCH*CHW + 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef logic [EW-1:0] ent_t;

  // ---------------- clock / reset ----------------
  logic c_clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  always #5 c_clk = ~c_clk;

  calc_scoreboard_if #(.NCH(NCH), .DW(DW), .RW(RW), .DEPTH(DEPTH), .CW(CW)) sb_if ();

  calc_scoreboard #(.NCH(NCH), .DW(DW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .clear (clear),
    .sb    (sb_if)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // stimulus for the next cycle, per channel
  logic [RW-1:0] s_er [NCH];
  logic [DW-1:0] s_ed [NCH];
  logic [RW-1:0] s_dr [NCH];
  logic [DW-1:0] s_dd [NCH];
  logic          s_clear;

  // reference model state
  ent_t mq [NCH][$];
  int   head_since [NCH];
  int   m_match [NCH];
  int   m_err   [NCH];
  bit   m_sticky;
  bit   m_last_any;
  int   cyc;

  task automatic check(input string name, input int ch, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ch=%0d got=%0h exp=%0h t=%0t", name, ch, got, exp, $time);
    end
  endtask

  function automatic int judge(input ent_t ref_e, input logic [RW-1:0] r, input logic [DW-1:0] d);
    logic [RW-1:0] rr;
    logic [DW-1:0] rd;
    {rr, rd} = ref_e;
    if (rr != r) return 2;
    if (r == RW'(1) && rd != d) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      head_since[c] = 0;
      m_match[c]    = 0;
      m_err[c]      = 0;
    end
    m_sticky   = 1'b0;
    m_last_any = 1'b0;
  endtask

  // Applies one cycle of stimulus to the model and queues the outputs expected after the edge.
  task automatic model_step();
    logic [W-1:0] snap;
    bit any;
    bit idle;
    snap = '0;
    any  = 1'b0;
    idle = 1'b1;
    if (s_clear) begin
      model_reset();
      snap[NCH*CHW +: 2] = 2'b01;
      exp_q.push_back(snap);
      cyc++;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      int code;
      int n;
      bit push, pop;
      ent_t inc, ref_e;
      code = 0;
      n    = mq[c].size();
      push = (s_er[c] != 0);
      pop  = (s_dr[c] != 0);
      inc  = {s_er[c], s_ed[c]};
      if (pop) begin
        if (n == 0 && !push) begin
          code = 3;
        end else begin
          if (n == 0) begin
            ref_e = inc;
          end else begin
            ref_e = mq[c].pop_front();
            if (push) mq[c].push_back(inc);
            head_since[c] = cyc;
          end
          code = judge(ref_e, s_dr[c], s_dd[c]);
          if (code == 0 && m_match[c] < CNT_MAX) m_match[c]++;
        end
      end else begin
        if (n > 0 && (cyc - head_since[c]) >= TIMEOUT) begin
          void'(mq[c].pop_front());
          head_since[c] = cyc;
          code = 5;
        end
        if (push) begin
          if (n == DEPTH) begin
            code = 4;
          end else begin
            if (mq[c].size() == 0) head_since[c] = cyc;
            mq[c].push_back(inc);
          end
        end
      end
      if (code != 0) begin
        any = 1'b1;
        if (m_err[c] < CNT_MAX) m_err[c]++;
      end
      if (mq[c].size() != 0) idle = 1'b0;
      snap[c*CHW +: CHW] = {CW'(m_match[c]), CW'(m_err[c]), PW'(mq[c].size()), 3'(code), code != 0};
    end
    m_sticky   = m_sticky | m_last_any;
    m_last_any = any;
    snap[NCH*CHW +: 2] = {m_sticky, idle};
    exp_q.push_back(snap);
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic zero_stim();
    for (int c = 0; c < NCH; c++) begin
      s_er[c] = '0;
      s_ed[c] = '0;
      s_dr[c] = '0;
      s_dd[c] = '0;
    end
    s_clear = 1'b0;
  endtask

  task automatic step();
    @(negedge c_clk);
    for (int c = 0; c < NCH; c++) begin
      sb_if.exp_resp[c*RW +: RW] = s_er[c];
      sb_if.exp_data[c*DW +: DW] = s_ed[c];
      sb_if.duv_resp[c*RW +: RW] = s_dr[c];
      sb_if.duv_data[c*DW +: DW] = s_dd[c];
    end
    clear = s_clear;
    model_step();
    zero_stim();
  endtask

  task automatic settle();
    @(posedge c_clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge c_clk);
    sb_if.exp_resp = '0;
    sb_if.exp_data = '0;
    sb_if.duv_resp = '0;
    sb_if.duv_data = '0;
    clear = 1'b0;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("rst_pending_ch2", 2, 32'(sb_if.pending[2*PW +: PW]), 0);
    check("rst_all_idle", -1, 32'(sb_if.all_idle), 1);
    check("rst_match_cnt", -1, 32'(|sb_if.match_cnt), 0);
    check("rst_err_cnt", -1, 32'(|sb_if.err_cnt), 0);
    check("rst_err_pulse", -1, 32'(sb_if.err_pulse), 0);
    check("rst_err_sticky", -1, 32'(sb_if.err_sticky), 0);
    @(negedge c_clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2*DEPTH + 2; k++) begin
      bit busy;
      busy = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (mq[c].size() > 0) begin
          {s_dr[c], s_dd[c]} = mq[c][0];
          busy = 1'b1;
        end
      end
      if (!busy) break;
      step();
    end
  endtask

  task automatic random_traffic(input int cycles, input int push_pct, input int pop_pct);
    for (int i = 0; i < cycles; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(99) < push_pct) begin
          s_er[c] = RW'($urandom_range(3, 1));
          s_ed[c] = DW'($urandom_range(3));
        end
        if ($urandom_range(99) < pop_pct) begin
          if (mq[c].size() > 0 && $urandom_range(9) < 7) begin
            {s_dr[c], s_dd[c]} = mq[c][0];
          end else if (mq[c].size() == 0 && s_er[c] != 0 && $urandom_range(1) == 1) begin
            s_dr[c] = s_er[c];
            s_dd[c] = s_ed[c];
          end else begin
            s_dr[c] = RW'($urandom_range(3, 1));
            s_dd[c] = DW'($urandom_range(3));
          end
        end
      end
      s_clear = ($urandom_range(399) == 0);
      step();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] e, g;
    forever begin
      @(posedge c_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '0;
        for (int c = 0; c < NCH; c++) begin
          g[c*CHW +: CHW] = {sb_if.match_cnt[c*CW +: CW], sb_if.err_cnt[c*CW +: CW],
                             sb_if.pending[c*PW +: PW], sb_if.err_code[c*3 +: 3], sb_if.err_pulse[c]};
        end
        g[NCH*CHW +: 2] = {sb_if.err_sticky, sb_if.all_idle};
        for (int c = 0; c < NCH; c++) begin
          check("pulse_code", c, 32'(g[c*CHW +: 4]), 32'(e[c*CHW +: 4]));
          check("pending", c, 32'(g[c*CHW+4 +: PW]), 32'(e[c*CHW+4 +: PW]));
          check("err_cnt", c, 32'(g[c*CHW+4+PW +: CW]), 32'(e[c*CHW+4+PW +: CW]));
          check("match_cnt", c, 32'(g[c*CHW+4+PW+CW +: CW]), 32'(e[c*CHW+4+PW+CW +: CW]));
        end
        check("err_sticky", -1, 32'(g[NCH*CHW+1]), 32'(e[NCH*CHW+1]));
        check("all_idle", -1, 32'(g[NCH*CHW]), 32'(e[NCH*CHW]));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int seen;
    logic [2:0] seen_code;
    cyc = 0;
    zero_stim();
    model_reset();
    sb_if.exp_resp = '0;
    sb_if.exp_data = '0;
    sb_if.duv_resp = '0;
    sb_if.duv_data = '0;
    apply_reset();

    // delayed DUV response matches a queued entry
    s_er[1] = 2'd1; s_ed[1] = 32'h0000_0005; step();
    step(); step();
    s_dr[1] = 2'd1; s_dd[1] = 32'h0000_0005; step(); settle();
    check("delayed_match_pulse", 1, 32'(sb_if.err_pulse[1]), 0);
    check("delayed_match_cnt", 1, 32'(sb_if.match_cnt[1*CW +: CW]), 1);

    // data mismatch, then response-code mismatch
    s_er[3] = 2'd1; s_ed[3] = 32'd7; step();
    s_dr[3] = 2'd1; s_dd[3] = 32'd8; step(); settle();
    check("data_mismatch_pulse", 3, 32'(sb_if.err_pulse[3]), 1);
    check("data_mismatch_code", 3, 32'(sb_if.err_code[3*3 +: 3]), 1);
    s_er[3] = 2'd2; step();
    s_dr[3] = 2'd1; step(); settle();
    check("resp_mismatch_code", 3, 32'(sb_if.err_code[3*3 +: 3]), 2);

    // unexpected response, then same-cycle bypass on an empty queue
    s_dr[0] = 2'd1; step(); settle();
    check("unexpected_code", 0, 32'(sb_if.err_code[0 +: 3]), 3);
    s_er[0] = 2'd1; s_ed[0] = 32'h10; s_dr[0] = 2'd1; s_dd[0] = 32'h10; step(); settle();
    check("bypass_pulse", 0, 32'(sb_if.err_pulse[0]), 0);
    check("bypass_pending", 0, 32'(sb_if.pending[0 +: PW]), 0);

    // fill to DEPTH, overflow on the extra push, then push+pop while full
    for (int i = 0; i <= DEPTH; i++) begin
      s_er[1] = 2'd1; s_ed[1] = DW'(i); step();
    end
    settle();
    check("overflow_code", 1, 32'(sb_if.err_code[1*3 +: 3]), 4);
    check("overflow_pending", 1, 32'(sb_if.pending[1*PW +: PW]), DEPTH);
    s_er[1] = 2'd1; s_ed[1] = 32'd100; s_dr[1] = 2'd1; s_dd[1] = 32'd0; step(); settle();
    check("full_pushpop_pulse", 1, 32'(sb_if.err_pulse[1]), 0);
    check("full_pushpop_pending", 1, 32'(sb_if.pending[1*PW +: PW]), DEPTH);
    drain();

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      s_er[2] = 2'd1; s_ed[2] = DW'(i + 20); step();
    end
    settle();
    check("prereset_pending", 2, 32'(sb_if.pending[2*PW +: PW]), 3);
    apply_reset();

    // timeout lands exactly TIMEOUT cycles after the push
    s_er[2] = 2'd1; s_ed[2] = 32'd9; step(); settle();
    seen = -1;
    seen_code = '0;
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      step(); settle();
      if (seen < 0 && sb_if.err_pulse[2]) begin
        seen      = i;
        seen_code = sb_if.err_code[2*3 +: 3];
      end
    end
    check("timeout_cycle", 2, 32'(seen), TIMEOUT);
    check("timeout_code", 2, 32'(seen_code), 5);
    check("timeout_pending", 2, 32'(sb_if.pending[2*PW +: PW]), 0);

    // random traffic: push-heavy then pop-heavy
    random_traffic(800, 60, 35);
    random_traffic(800, 30, 55);
    drain();

    // counter saturation
    s_clear = 1'b1; step();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      s_er[0] = 2'd2; s_ed[0] = $urandom;
      s_dr[0] = 2'd2; s_dd[0] = $urandom;
      s_dr[3] = 2'd1;
      step();
    end
    settle();
    check("match_saturate", 0, 32'(sb_if.match_cnt[0 +: CW]), CNT_MAX);
    check("err_saturate", 3, 32'(sb_if.err_cnt[3*CW +: CW]), CNT_MAX);
    check("sticky_after_errors", -1, 32'(sb_if.err_sticky), 1);

    step(); settle();
    check("exp_q_leftover", -1, 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
